game_scheduler: RTL and testbench

GAME_SCHEDULER -- requirements
Module: game_scheduler

---
 rtl/game_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_game_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/game_scheduler.sv
// Snake game step scheduler: synchronises buttons, queues turns, paces steps off
// the frame pulse and hands each step to the game engine with a request/done handshake.
module game_scheduler #(
    parameter int unsigned FRAMES_INIT = 8,
    parameter int unsigned FRAMES_MIN  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_frame,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_restart,
    input  logic       i_step_done,
    input  logic       i_eat,
    input  logic       i_failure,
    input  logic       i_success,
    output logic       o_step,
    output logic [1:0] o_dir,
    output logic       o_clear,
    output logic [1:0] o_state
);

    localparam int unsigned PW = $clog2(FRAMES_INIT + 1);
    localparam logic [PW-1:0] P_INIT = PW'(FRAMES_INIT);
    localparam logic [PW-1:0] P_MIN  = PW'(FRAMES_MIN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_OVER = 2'd3
    } state_e;

    logic [4:0] btn_raw, sync1_q, sync2_q, prev_q, btn_edge;

    state_e        state_q, state_d;
    logic          step_q, step_d;
    logic [1:0]    dir_q, dir_d;
    logic          clear_q, clear_d;
    logic [PW-1:0] period_q, period_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [1:0]    q0_q, q0_d, q1_q, q1_d;
    logic [1:0]    qcnt_q, qcnt_d;
    logic          pend_q, pend_d;
    logic          reissue_q, reissue_d;

    logic          dir_evt;
    logic [1:0]    dir_new;
    logic          due, pop, dir_ok;
    logic [1:0]    ref_dir;

    assign btn_raw  = {i_restart, i_right, i_left, i_down, i_up};
    assign btn_edge = sync2_q & ~prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        dir_evt = |btn_edge[3:0];
        dir_new = 2'd3;
        if (btn_edge[0])      dir_new = 2'd0;
        else if (btn_edge[1]) dir_new = 2'd1;
        else if (btn_edge[2]) dir_new = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            step_q    <= 1'b0;
            dir_q     <= 2'd3;
            clear_q   <= 1'b0;
            period_q  <= P_INIT;
            cnt_q     <= '0;
            q0_q      <= '0;
            q1_q      <= '0;
            qcnt_q    <= '0;
            pend_q    <= 1'b0;
            reissue_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            clear_q   <= clear_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            q0_q      <= q0_d;
            q1_q      <= q1_d;
            qcnt_q    <= qcnt_d;
            pend_q    <= pend_d;
            reissue_q <= reissue_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        dir_d     = dir_q;
        clear_d   = 1'b0;
        period_d  = period_q;
        cnt_d     = cnt_q;
        q0_d      = q0_q;
        q1_d      = q1_q;
        qcnt_d    = qcnt_q;
        pend_d    = pend_q;
        reissue_d = 1'b0;
        due       = 1'b0;
        pop       = 1'b0;
        dir_ok    = 1'b0;
        ref_dir   = dir_q;

        if (btn_edge[4]) begin
            clear_d  = 1'b1;
            state_d  = S_IDLE;
            step_d   = 1'b0;
            dir_d    = 2'd3;
            period_d = P_INIT;
            cnt_d    = '0;
            qcnt_d   = '0;
            pend_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dir_evt) begin
                        dir_d   = dir_new;
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end
                end
                S_RUN, S_WAIT: begin
                    if (i_failure || i_success) begin
                        state_d = S_OVER;
                        step_d  = 1'b0;
                        qcnt_d  = '0;
                        pend_d  = 1'b0;
                    end else begin
                        // >= rather than == so a period shrunk below the count still wraps
                        if (i_frame) begin
                            due   = (cnt_q >= period_q - PW'(1));
                            cnt_d = due ? '0 : cnt_q + PW'(1);
                        end
                        if (i_eat)
                            period_d = (period_q > P_MIN) ? period_q - PW'(1) : P_MIN;

                        if (state_q == S_RUN) begin
                            if (due) begin
                                pop     = 1'b1;
                                step_d  = 1'b1;
                                state_d = S_WAIT;
                            end
                        end else begin
                            if (due)
                                pend_d = 1'b1;
                            // A pending step is re-issued one cycle after the ack so o_step shows a low cycle
                            if (reissue_q) begin
                                pop    = 1'b1;
                                step_d = 1'b1;
                            end else if (i_step_done) begin
                                step_d = 1'b0;
                                if (pend_q || due) begin
                                    pend_d    = 1'b0;
                                    reissue_d = 1'b1;
                                end else begin
                                    state_d = S_RUN;
                                end
                            end
                        end

                        if (pop && qcnt_q != 2'd0) begin
                            dir_d  = q0_q;
                            q0_d   = q1_q;
                            qcnt_d = qcnt_q - 2'd1;
                        end

                        if (qcnt_d == 2'd2)      ref_dir = q1_d;
                        else if (qcnt_d == 2'd1) ref_dir = q0_d;
                        else                     ref_dir = dir_d;

                        dir_ok = dir_evt && (dir_new != ref_dir) &&
                                 (dir_new != (ref_dir ^ 2'b01)) && (qcnt_d != 2'd2);
                        if (dir_ok) begin
                            if (qcnt_d == 2'd0) q0_d = dir_new;
                            else                q1_d = dir_new;
                            qcnt_d = qcnt_d + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_step  = step_q;
    assign o_dir   = dir_q;
    assign o_clear = clear_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_game_scheduler.sv
// Directed bench for game_scheduler: one task per scenario, hand-computed expectations.
module tb_game_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_frame, i_up, i_down, i_left, i_right, i_restart;
    logic       i_step_done, i_eat, i_failure, i_success;
    logic       o_step, o_clear;
    logic [1:0] o_dir, o_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    game_scheduler #(.FRAMES_INIT(8), .FRAMES_MIN(2)) dut (
        .clk(clk), .rst(rst), .i_frame(i_frame),
        .i_up(i_up), .i_down(i_down), .i_left(i_left), .i_right(i_right),
        .i_restart(i_restart), .i_step_done(i_step_done), .i_eat(i_eat),
        .i_failure(i_failure), .i_success(i_success),
        .o_step(o_step), .o_dir(o_dir), .o_clear(o_clear), .o_state(o_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int unsigned b, input logic v);
        case (b)
            0:       i_up      = v;
            1:       i_down    = v;
            2:       i_left    = v;
            3:       i_right   = v;
            default: i_restart = v;
        endcase
    endtask

    // Held long enough for sync + edge detect, then released long enough to re-arm.
    task automatic press(input int unsigned b);
        set_btn(b, 1'b1);
        repeat (3) tick();
        set_btn(b, 1'b0);
        repeat (3) tick();
    endtask

    task automatic frame();
        i_frame = 1'b1; tick();
        i_frame = 1'b0; tick();
    endtask

    task automatic step_done();
        i_step_done = 1'b1; tick();
        i_step_done = 1'b0; tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {i_frame, i_up, i_down, i_left, i_right, i_restart} = '0;
        {i_step_done, i_eat, i_failure, i_success} = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total++; if (o_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", o_state); end
        total++; if (o_step !== 1'b0) begin bad++; $display("FAIL reset_step: got %0d want 0", o_step); end
        total++; if (o_dir !== 2'd3) begin bad++; $display("FAIL reset_dir: got %0d want 3", o_dir); end
        total++; if (o_clear !== 1'b0) begin bad++; $display("FAIL reset_clear: got %0d want 0", o_clear); end
        repeat (10) frame();
        total++; if (o_state !== 2'd0 || o_step !== 1'b0)
            begin bad++; $display("FAIL idle_no_step: got state=%0d step=%0d want 0/0", o_state, o_step); end
    endtask

    task automatic test_first_step();
        press(0);
        total++; if (o_state !== 2'd1) begin bad++; $display("FAIL first_run_state: got %0d want 1", o_state); end
        total++; if (o_dir !== 2'd0) begin bad++; $display("FAIL first_dir_load: got %0d want 0", o_dir); end
        for (int i = 1; i < 8; i++) begin
            frame();
            total++; if (o_step !== 1'b0) begin bad++; $display("FAIL early_step f%0d: got %0d want 0", i, o_step); end
        end
        frame();
        total++; if (o_step !== 1'b1) begin bad++; $display("FAIL first_step: got %0d want 1", o_step); end
        total++; if (o_state !== 2'd2) begin bad++; $display("FAIL first_wait_state: got %0d want 2", o_state); end
        total++; if (o_dir !== 2'd0) begin bad++; $display("FAIL first_step_dir: got %0d want 0", o_dir); end
        step_done();
        total++; if (o_step !== 1'b0 || o_state !== 2'd1)
            begin bad++; $display("FAIL first_ack: got step=%0d state=%0d want 0/1", o_step, o_state); end
    endtask

    task automatic test_queue();
        press(4);
        press(3);
        total++; if (o_state !== 2'd1 || o_dir !== 2'd3)
            begin bad++; $display("FAIL q_start: got state=%0d dir=%0d want 1/3", o_state, o_dir); end
        press(2);
        press(0);
        press(1);
        repeat (8) frame();
        total++; if (o_step !== 1'b1 || o_dir !== 2'd0)
            begin bad++; $display("FAIL q_step1: got step=%0d dir=%0d want 1/0", o_step, o_dir); end
        step_done();
        repeat (8) frame();
        total++; if (o_step !== 1'b1 || o_dir !== 2'd0)
            begin bad++; $display("FAIL q_step2_down_dropped: got step=%0d dir=%0d want 1/0", o_step, o_dir); end
        step_done();
        press(2);
        press(0);
        press(3);
        repeat (8) frame();
        total++; if (o_dir !== 2'd2) begin bad++; $display("FAIL q_full_1: got %0d want 2", o_dir); end
        step_done();
        repeat (8) frame();
        total++; if (o_dir !== 2'd0) begin bad++; $display("FAIL q_full_2: got %0d want 0", o_dir); end
        step_done();
        repeat (8) frame();
        total++; if (o_dir !== 2'd0) begin bad++; $display("FAIL q_full_3_right_dropped: got %0d want 0", o_dir); end
        step_done();
    endtask

    task automatic test_pending();
        repeat (8) frame();
        total++; if (o_step !== 1'b1 || o_state !== 2'd2)
            begin bad++; $display("FAIL pend_issue: got step=%0d state=%0d want 1/2", o_step, o_state); end
        press(2);
        repeat (8) frame();
        total++; if (o_step !== 1'b1 || o_state !== 2'd2 || o_dir !== 2'd0)
            begin bad++; $display("FAIL pend_hold: got step=%0d state=%0d dir=%0d want 1/2/0", o_step, o_state, o_dir); end
        i_step_done = 1'b1; tick();
        total++; if (o_step !== 1'b0 || o_state !== 2'd2)
            begin bad++; $display("FAIL pend_low_cycle: got step=%0d state=%0d want 0/2", o_step, o_state); end
        i_step_done = 1'b0; tick();
        total++; if (o_step !== 1'b1 || o_dir !== 2'd2)
            begin bad++; $display("FAIL pend_reissue: got step=%0d dir=%0d want 1/2", o_step, o_dir); end
        step_done();
        total++; if (o_step !== 1'b0 || o_state !== 2'd1)
            begin bad++; $display("FAIL pend_back_run: got step=%0d state=%0d want 0/1", o_step, o_state); end
    endtask

    task automatic test_eat();
        press(4);
        press(0);
        repeat (7) begin
            i_eat = 1'b1; tick();
            i_eat = 1'b0; tick();
        end
        frame();
        total++; if (o_step !== 1'b0) begin bad++; $display("FAIL eat_min_f1: got %0d want 0", o_step); end
        frame();
        total++; if (o_step !== 1'b1) begin bad++; $display("FAIL eat_min_f2: got %0d want 1", o_step); end
        step_done();
        frame();
        total++; if (o_step !== 1'b0) begin bad++; $display("FAIL eat_min_f3: got %0d want 0", o_step); end
        frame();
        total++; if (o_step !== 1'b1 || o_state !== 2'd2)
            begin bad++; $display("FAIL eat_min_f4: got step=%0d state=%0d want 1/2", o_step, o_state); end
    endtask

    task automatic test_game_over();
        press(2);
        i_failure = 1'b1; tick();
        i_failure = 1'b0;
        total++; if (o_state !== 2'd3 || o_step !== 1'b0)
            begin bad++; $display("FAIL over_enter: got state=%0d step=%0d want 3/0", o_state, o_step); end
        tick();
        press(1);
        repeat (4) frame();
        total++; if (o_state !== 2'd3 || o_step !== 1'b0 || o_dir !== 2'd0)
            begin bad++; $display("FAIL over_ignore: got state=%0d step=%0d dir=%0d want 3/0/0", o_state, o_step, o_dir); end
        i_restart = 1'b1; tick(); tick();
        total++; if (o_clear !== 1'b0) begin bad++; $display("FAIL clear_early: got %0d want 0", o_clear); end
        tick();
        total++; if (o_clear !== 1'b1 || o_state !== 2'd0 || o_dir !== 2'd3)
            begin bad++; $display("FAIL clear_pulse: got clr=%0d state=%0d dir=%0d want 1/0/3", o_clear, o_state, o_dir); end
        tick();
        total++; if (o_clear !== 1'b0) begin bad++; $display("FAIL clear_one_cycle: got %0d want 0", o_clear); end
        i_restart = 1'b0;
        repeat (3) tick();
        press(0);
        repeat (7) frame();
        total++; if (o_step !== 1'b0) begin bad++; $display("FAIL period_reinit_f7: got %0d want 0", o_step); end
        frame();
        total++; if (o_step !== 1'b1 || o_dir !== 2'd0)
            begin bad++; $display("FAIL period_reinit_f8: got step=%0d dir=%0d want 1/0", o_step, o_dir); end
        step_done();
    endtask

    task automatic test_restart_collision();
        repeat (8) frame();
        press(2);
        i_restart = 1'b1; i_right = 1'b1;
        tick(); tick();
        i_step_done = 1'b1; tick();
        total++; if (o_clear !== 1'b1 || o_state !== 2'd0 || o_step !== 1'b0 || o_dir !== 2'd3)
            begin bad++; $display("FAIL collide: got clr=%0d state=%0d step=%0d dir=%0d want 1/0/0/3", o_clear, o_state, o_step, o_dir); end
        i_step_done = 1'b0; i_restart = 1'b0; i_right = 1'b0;
        tick();
        total++; if (o_clear !== 1'b0 || o_state !== 2'd0)
            begin bad++; $display("FAIL collide_after: got clr=%0d state=%0d want 0/0", o_clear, o_state); end
        repeat (3) tick();
        press(0);
        repeat (8) frame();
        total++; if (o_step !== 1'b1 || o_dir !== 2'd0)
            begin bad++; $display("FAIL collide_queue_flushed: got step=%0d dir=%0d want 1/0", o_step, o_dir); end
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_queue();
        test_pending();
        test_eat();
        test_game_over();
        test_restart_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
